// File: rtl/attr_reclass_seq_pkg.sv
// Shared types and class-code constants for the AttrReclass frame sequencer.
package tinyspu_pkg;

    typedef enum logic [2:0] {
        CFG_A = 3'd0,
        CFG_B = 3'd1,
        CFG_D = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [3:0] CLS3_HI  = 4'd1;
    localparam logic [3:0] CLS3_MID = 4'd2;
    localparam logic [3:0] CLS3_LO  = 4'd3;
    localparam logic [3:0] CLS2_GE  = 4'd0;
    localparam logic [3:0] CLS2_LT  = 4'd5;

endpackage

// File: rtl/attr_reclass_seq_reclass.sv
// AttrReclass comparator: purely combinational 3-class / 2-class coding of C.
module attr_reclass_seq_reclass
    import tinyspu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] c_i,
    input  logic [3:0] d_i,
    output logic [3:0] m_o,
    output logic [3:0] n_o
);

    // Unsigned 4-bit compares; B>A leaves the middle class unreachable.
    always_comb begin
        m_o = CLS3_LO;
        if (c_i > a_i)
            m_o = CLS3_HI;
        else if (c_i >= b_i)
            m_o = CLS3_MID;
        n_o = (c_i >= d_i) ? CLS2_GE : CLS2_LT;
    end

endmodule

// File: rtl/attr_reclass_seq.sv
// Frame sequencer: three config beats (A, B, D), then CELLS cells through
// AttrReclass with a one-deep registered result stage and class histograms.
module attr_reclass_seq
    import tinyspu_pkg::*;
#(
    parameter int CELLS = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_data,
    output logic             cfg_ready,
    input  logic             s_valid,
    input  logic [3:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [3:0]       m_cls3,
    output logic [3:0]       m_cls2,
    output logic             m_last,
    input  logic             m_ready,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam int CIW = $clog2(CELLS + 1);
    localparam logic [CIW-1:0] IDX_END  = CIW'(CELLS);
    localparam logic [CIW-1:0] IDX_LAST = CIW'(CELLS - 1);

    state_e           state_q, state_d;
    logic [3:0]       a_q, b_q, d_q;
    logic [CIW-1:0]   idx_q;
    logic             m_valid_q, m_last_q, cfg_err_q;
    logic [3:0]       m_cls3_q, m_cls2_q;
    logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt3_q;
    logic [3:0]       cls3_w, cls2_w;
    logic             cfg_acc, s_acc, drain;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    attr_reclass_seq_reclass u_reclass (
        .a_i (a_q),
        .b_i (b_q),
        .c_i (s_data),
        .d_i (d_q),
        .m_o (cls3_w),
        .n_o (cls2_w)
    );

    assign cfg_acc = cfg_valid & cfg_ready;
    assign s_acc   = s_valid & s_ready;
    assign drain   = m_valid_q & m_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= CFG_A;
        else
            state_q <= state_d;
    end

    // Next-state: config beats, then run until the last result is drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_A:   if (cfg_acc) state_d = CFG_B;
            CFG_B:   if (cfg_acc) state_d = CFG_D;
            CFG_D:   if (cfg_acc) state_d = RUN;
            RUN:     if (drain && m_last_q) state_d = DONE;
            DONE:    state_d = CFG_A;
            default: state_d = CFG_A;
        endcase
    end

    // Handshake outputs decoded from state; a held result blocks new cells.
    always_comb begin
        cfg_ready = (state_q == CFG_A) || (state_q == CFG_B) || (state_q == CFG_D);
        s_ready   = (state_q == RUN) && (idx_q < IDX_END) && (!m_valid_q || m_ready);
        done      = (state_q == DONE);
    end

    // Thresholds, cell index, result stage and histograms.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_cls3_q  <= '0;
            m_cls2_q  <= '0;
            m_last_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            cnt3_q    <= '0;
        end else begin
            if (cfg_acc) begin
                case (state_q)
                    CFG_A: begin
                        a_q       <= cfg_data;
                        cfg_err_q <= 1'b0;
                        cnt1_q    <= '0;
                        cnt2_q    <= '0;
                        cnt3_q    <= '0;
                    end
                    CFG_B:   b_q <= cfg_data;
                    CFG_D: begin
                        d_q       <= cfg_data;
                        cfg_err_q <= (b_q > a_q);
                    end
                    default: ;
                endcase
            end

            if (s_acc) begin
                m_valid_q <= 1'b1;
                m_cls3_q  <= cls3_w;
                m_cls2_q  <= cls2_w;
                m_last_q  <= (idx_q == IDX_LAST);
                idx_q     <= idx_q + 1'b1;
                case (cls3_w)
                    CLS3_HI:  cnt1_q <= sat_inc(cnt1_q);
                    CLS3_MID: cnt2_q <= sat_inc(cnt2_q);
                    default:  cnt3_q <= sat_inc(cnt3_q);
                endcase
            end else if (drain) begin
                m_valid_q <= 1'b0;
            end

            // No cell can be accepted once idx reached CELLS, so this never
            // collides with the increment above.
            if (drain && m_last_q)
                idx_q <= '0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_cls3  = m_cls3_q;
    assign m_cls2  = m_cls2_q;
    assign m_last  = m_last_q;
    assign cfg_err = cfg_err_q;
    assign cnt1    = cnt1_q;
    assign cnt2    = cnt2_q;
    assign cnt3    = cnt3_q;

endmodule

// File: tb/tb_attr_reclass_seq.sv
// Bench for attr_reclass_seq: two instances (CNT_W=8 and CNT_W=2) share all
// inputs; table-driven frames, hand sequences and random frames.
module tb_attr_reclass_seq;

    localparam int CELLS = 6;

    logic clk = 1'b0;
    logic rst, cfg_valid, s_valid, m_ready;
    logic [3:0] cfg_data, s_data;

    logic       cfg_ready_o[2], s_ready_o[2], m_valid_o[2], m_last_o[2];
    logic       done_o[2], cfg_err_o[2];
    logic [3:0] m_cls3_o[2], m_cls2_o[2];
    logic [7:0] c1_a, c2_a, c3_a;
    logic [1:0] c1_b, c2_b, c3_b;

    always #5 clk = ~clk;

    attr_reclass_seq #(.CELLS(CELLS), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready_o[0]), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_o[0]), .m_valid(m_valid_o[0]), .m_cls3(m_cls3_o[0]),
        .m_cls2(m_cls2_o[0]), .m_last(m_last_o[0]), .m_ready(m_ready),
        .done(done_o[0]), .cfg_err(cfg_err_o[0]),
        .cnt1(c1_a), .cnt2(c2_a), .cnt3(c3_a)
    );

    attr_reclass_seq #(.CELLS(CELLS), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready_o[1]), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_o[1]), .m_valid(m_valid_o[1]), .m_cls3(m_cls3_o[1]),
        .m_cls2(m_cls2_o[1]), .m_last(m_last_o[1]), .m_ready(m_ready),
        .done(done_o[1]), .cfg_err(cfg_err_o[1]),
        .cnt1(c1_b), .cnt2(c2_b), .cnt3(c3_b)
    );

    typedef struct {
        logic [3:0]       a, b, d;
        logic [5:0][3:0]  c, m, n;
        int               c1, c2, c3;
        bit               err;
    } frame_t;

    int tests = 0;
    int fails = 0;
    frame_t tbl[4];
    int vc[6], vm[6], vn[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int cap3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk_cnts(input string tag, input int e1, input int e2, input int e3);
        chk({tag, " a.cnt1"}, c1_a, e1);
        chk({tag, " a.cnt2"}, c2_a, e2);
        chk({tag, " a.cnt3"}, c3_a, e3);
        chk({tag, " b.cnt1"}, c1_b, cap3(e1));
        chk({tag, " b.cnt2"}, c2_b, cap3(e2));
        chk({tag, " b.cnt3"}, c3_b, cap3(e3));
    endtask

    // Reference classification straight from the class definitions.
    task automatic classify(input logic [3:0] a, b, c, d, output logic [3:0] m, n);
        if (c > a) m = 4'd1;
        else if (b <= c && c <= a) m = 4'd2;
        else m = 4'd3;
        n = (c >= d) ? 4'd0 : 4'd5;
    endtask

    task automatic set_row(input int i, input logic [3:0] a, b, d,
                           input int e1, e2, e3, input bit err);
        tbl[i].a = a; tbl[i].b = b; tbl[i].d = d;
        for (int k = 0; k < 6; k++) begin
            tbl[i].c[k] = 4'(vc[k]);
            tbl[i].m[k] = 4'(vm[k]);
            tbl[i].n[k] = 4'(vn[k]);
        end
        tbl[i].c1 = e1; tbl[i].c2 = e2; tbl[i].c3 = e3; tbl[i].err = err;
    endtask

    task automatic do_cfg(input logic [3:0] a, b, d);
        logic [3:0] v[3];
        v[0] = a; v[1] = b; v[2] = d;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = v[i];
            s_valid   = 1'b1;
            s_data    = 4'($urandom);
            m_ready   = 1'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cfg%0d d%0d cfg_ready", i, k), cfg_ready_o[k], 1);
                chk($sformatf("cfg%0d d%0d s_ready", i, k), s_ready_o[k], 0);
                chk($sformatf("cfg%0d d%0d m_valid", i, k), m_valid_o[k], 0);
            end
            step;
            if (i == 0) begin
                for (int k = 0; k < 2; k++)
                    chk($sformatf("after A d%0d cfg_err", k), cfg_err_o[k], 0);
                chk_cnts("after A", 0, 0, 0);
            end
        end
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
    endtask

    // mode 0: always ready; 1: m_ready low cycles 3..5; 2: random valid/ready.
    // abort_at>0 stops once that many cells have been accepted.
    task automatic run_cells(input frame_t f, input int mode, input int abort_at);
        int sent = 0;
        int cyc = 0;
        bit pend = 0;
        bit fin = 0;
        bit exp_sr, drain, acc;
        logic [8:0] q[$];
        logic [8:0] h;
        while (!fin && cyc < 200) begin
            s_valid   = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data    = (sent < 6) ? f.c[sent] : 4'($urandom);
            m_ready   = (mode == 0) ? 1'b1 :
                        (mode == 1) ? !(cyc >= 3 && cyc <= 5) :
                        ($urandom_range(0, 2) != 0);
            cfg_valid = 1'($urandom);
            cfg_data  = 4'hF;
            #1;
            exp_sr = (sent < 6) && (!pend || m_ready);
            h = (q.size() > 0) ? q[0] : 9'd0;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("c%0d d%0d s_ready", cyc, k), s_ready_o[k], exp_sr);
                chk($sformatf("c%0d d%0d cfg_ready", cyc, k), cfg_ready_o[k], 0);
                chk($sformatf("c%0d d%0d done", cyc, k), done_o[k], 0);
                chk($sformatf("c%0d d%0d m_valid", cyc, k), m_valid_o[k], pend);
                if (cyc == 0)
                    chk($sformatf("d%0d cfg_err", k), cfg_err_o[k], f.err);
                if (pend) begin
                    chk($sformatf("c%0d d%0d m_cls3", cyc, k), m_cls3_o[k], h[8:5]);
                    chk($sformatf("c%0d d%0d m_cls2", cyc, k), m_cls2_o[k], h[4:1]);
                    chk($sformatf("c%0d d%0d m_last", cyc, k), m_last_o[k], h[0]);
                end
            end
            drain = pend && m_ready;
            if (drain) begin
                if (h[0]) fin = 1;
                void'(q.pop_front());
            end
            acc = s_valid && exp_sr;
            if (acc) begin
                q.push_back({f.m[sent], f.n[sent], sent == 5});
                sent++;
            end
            pend = acc ? 1'b1 : (drain ? 1'b0 : pend);
            cyc++;
            step;
            if (abort_at != 0 && sent == abort_at) break;
        end
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        if (abort_at != 0) return;
        if (!fin) chk("frame_timeout", 0, 1);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("DONE d%0d done", k), done_o[k], 1);
            chk($sformatf("DONE d%0d s_ready", k), s_ready_o[k], 0);
            chk($sformatf("DONE d%0d m_valid", k), m_valid_o[k], 0);
            chk($sformatf("DONE d%0d cfg_err", k), cfg_err_o[k], f.err);
        end
        chk_cnts("DONE", f.c1, f.c2, f.c3);
        step;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post d%0d done", k), done_o[k], 0);
            chk($sformatf("post d%0d cfg_ready", k), cfg_ready_o[k], 1);
        end
        chk_cnts("post", f.c1, f.c2, f.c3);
    endtask

    initial begin
        frame_t rf;
        logic [3:0] mm, nn;

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step;
        step;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst d%0d m_valid", k), m_valid_o[k], 0);
            chk($sformatf("rst d%0d m_cls3", k), m_cls3_o[k], 0);
            chk($sformatf("rst d%0d m_cls2", k), m_cls2_o[k], 0);
            chk($sformatf("rst d%0d m_last", k), m_last_o[k], 0);
            chk($sformatf("rst d%0d done", k), done_o[k], 0);
            chk($sformatf("rst d%0d cfg_err", k), cfg_err_o[k], 0);
            chk($sformatf("rst d%0d cfg_ready", k), cfg_ready_o[k], 1);
        end
        chk_cnts("rst", 0, 0, 0);
        rst = 1'b0;

        // basic frame
        vc = '{12, 10, 4, 3, 7, 6}; vm = '{1, 2, 2, 3, 2, 2}; vn = '{0, 0, 5, 5, 0, 5};
        set_row(0, 4'd10, 4'd4, 4'd7, 1, 4, 1, 1'b0);
        // bad config (B > A)
        vc = '{2, 5, 3, 9, 0, 15}; vm = '{3, 1, 3, 1, 3, 1}; vn = '{0, 0, 0, 0, 0, 0};
        set_row(1, 4'd3, 4'd9, 4'd0, 3, 0, 3, 1'b1);
        // equality boundaries, A=B=D
        vc = '{9, 10, 8, 0, 15, 9}; vm = '{2, 1, 3, 3, 1, 2}; vn = '{0, 0, 5, 5, 0, 0};
        set_row(2, 4'd9, 4'd9, 4'd9, 2, 2, 2, 1'b0);
        // saturation: all class 1
        vc = '{15, 15, 15, 15, 15, 15}; vm = '{1, 1, 1, 1, 1, 1}; vn = '{0, 0, 0, 0, 0, 0};
        set_row(3, 4'd10, 4'd4, 4'd7, 6, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_cfg(tbl[i].a, tbl[i].b, tbl[i].d);
            run_cells(tbl[i], 0, 0);
        end

        // backpressure mid-frame
        do_cfg(tbl[0].a, tbl[0].b, tbl[0].d);
        run_cells(tbl[0], 1, 0);

        // reset after three accepted cells, then a clean frame
        do_cfg(tbl[0].a, tbl[0].b, tbl[0].d);
        run_cells(tbl[0], 0, 3);
        rst = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
        step;
        rst = 1'b0; s_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst d%0d m_valid", k), m_valid_o[k], 0);
            chk($sformatf("midrst d%0d cfg_ready", k), cfg_ready_o[k], 1);
            chk($sformatf("midrst d%0d cfg_err", k), cfg_err_o[k], 0);
            chk($sformatf("midrst d%0d done", k), done_o[k], 0);
        end
        chk_cnts("midrst", 0, 0, 0);
        do_cfg(tbl[0].a, tbl[0].b, tbl[0].d);
        run_cells(tbl[0], 0, 0);

        // random frames against the reference classifier
        for (int r = 0; r < 15; r++) begin
            rf.a = 4'($urandom); rf.b = 4'($urandom); rf.d = 4'($urandom);
            rf.c1 = 0; rf.c2 = 0; rf.c3 = 0;
            rf.err = (rf.b > rf.a);
            for (int k = 0; k < 6; k++) begin
                rf.c[k] = (r < 3) ? rf.a : 4'($urandom);
                classify(rf.a, rf.b, rf.c[k], rf.d, mm, nn);
                rf.m[k] = mm; rf.n[k] = nn;
                if (mm == 4'd1) rf.c1++;
                else if (mm == 4'd2) rf.c2++;
                else rf.c3++;
            end
            do_cfg(rf.a, rf.b, rf.d);
            run_cells(rf, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
